mips5_pipeline_core: RTL and testbench
======================================

Name: mips5_pipeline_core

Overview:
- Single-issue, in-order, 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset integer core.
- Connects to two external single-port memories: instruction and data. Each memory has an asynchronous (combinational) read port and a synchronous write port (write on posedge when write_enable=1).
- Instruction memory is preloaded before reset is released. The core never writes it.

Parameters:
- ADDRESS_SIZE, 32, width of all memory address buses. Memories are word-addressed.
- DATA_SIZE, 32, instruction/data/register width.

Ports:
- clock  in  1  Core clock; all state updates on posedge.
- reset_n  in  1  Reset; one clock; reset is asynchronous and active-low.
- im_write_enable  out  1  Instruction memory write enable; tied 0.
- im_write_address  out  ADDRESS_SIZE  Tied 0.
- im_write_data  out  DATA_SIZE  Tied 0.
- im_read_address  out  ADDRESS_SIZE  Equals PC.
- im_read_data  in  DATA_SIZE  Instruction at PC, same cycle.
- dm_write_enable  out  1  Store strobe, combinational from MEM stage.
- dm_write_address  out  ADDRESS_SIZE  Store address.
- dm_write_data  out  DATA_SIZE  Store data.
- dm_read_address  out  ADDRESS_SIZE  Load address, combinational from MEM stage.
- dm_read_data  in  DATA_SIZE  Load data, same cycle.

Behaviour:
- ISA (word addressing, PC+1 per instruction):
  - R-type (op 0x00), funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - Immediate: addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - Any other op, or op 0 with any other funct, is a NOP.
- Arithmetic: wrap modulo 2^32, no overflow trap. Immediates are sign-extended. lw/sw address = rs + imm. beq target = PC_of_beq + 1 + imm.
- Register file: 32x32; $0 reads 0 and is never written. A read of the register being written in WB in the same cycle returns WB_value (write-through).
- Named pipeline signals (hierarchically probed by the bench; names fixed):
  - IF_ID_IR.
  - ID_EX_A, ID_EX_B, ID_EX_imm, ID_EX_rd, ID_EX_rt, ID_EX_op; also ID_EX_rs, ID_EX_funct, ID_EX_valid, ID_EX_pc.
  - EX_MEM_result, EX_MEM_dest, EX_MEM_op, EX_MEM_valid, EX_MEM_B.
  - MEM_WB_result, MEM_WB_data, MEM_WB_dest, MEM_WB_op, MEM_WB_valid.
  - WB_dest, WB_value, WB_WEenable.
  - ex_stall_c, mem_stall_c.
- Stage behaviour:
  - IF: IF_ID_IR <= im_read_data; PC <= PC+1.
  - ID: A = reg[rs], B = reg[rt], imm = sext(IR[15:0]), op = IR[31:26], rd/rt from IR.
  - EX: EX_MEM_result = ALU result. EX_MEM_dest = rd (R-type), rt (addi/lw), 0 (sw/beq/NOP).
  - MEM: dm_read_address = dm_write_address = EX_MEM_result; dm_write_data = EX_MEM_B; dm_write_enable = EX_MEM_valid && op==sw. MEM_WB_data <= dm_read_data.
  - WB (combinational from MEM_WB): WB_dest = MEM_WB_dest; WB_value = MEM_WB_data for lw, else MEM_WB_result; WB_WEenable = MEM_WB_valid && dest!=0.
- Hazards (no forwarding). ID source regs are rs, plus rt for R-type/sw/beq; a hazard exists only when the matching dest is nonzero.
  - ex_stall_c = 1 when a source equals ID_EX dest with ID_EX_valid.
  - mem_stall_c = 1 when a source equals EX_MEM_dest with EX_MEM_valid.
  - Either stall holds PC and IF_ID_IR and injects a bubble into ID_EX (valid=0, op=0).
- Branch: beq resolved in EX. If taken, PC <= target, IF_ID_IR <= 0, and ID_EX becomes a bubble. A taken branch overrides any stall in the same cycle.
- Reset (async, reset_n=0):
  - PC = 0.
  - All pipeline registers and register file = 0; all valid flags = 0.
  - Stall flags = 0; dm_write_enable = 0.
  - Reset mid-operation discards all in-flight instructions.
- Latency: an instruction fetched at edge N writes back combinationally after edge N+3 and commits at edge N+4.
- A stall occurring together with a store in MEM still performs the store.

Test Plan:
- Reset: hold reset_n=0 ten cycles → PC=0, IF_ID_IR=0, all *_valid=0, WB_WEenable=0; first edge after release → IF_ID_IR = imem[0].
- Independent ALU ops: imem = addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 → ex_stall_c=1 for the add; $3=12, WB_dest=3, WB_value=0x0000000C.
- Load-use: imem = sw $3,4($0); lw $4,4($0); sub $5,$4,$1 (with $3=12, $1=5) → dmem[4]=12; stall cycles observed; WB_value=7 for $5.
- Taken branch: beq $0,$0,+2 → the next two fetched instructions are squashed (IF_ID_IR=0, ID_EX_valid=0); PC=branch_pc+3.
- Write to $0: addi $0,$0,9 → WB_WEenable=0; $0 reads 0.
- slt signed: addi $1,$0,-1; slt $2,$1,$0 → $2=1.

Source files
------------

// File: rtl/mips5_pipeline_core.sv
`default_nettype none
// ============================================================================
// Module   : mips5_pipeline_core
// Brief    : 5-stage in-order MIPS-subset core, interlocked (no forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module mips5_pipeline_core #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    im_write_enable,
    output logic [ADDRESS_SIZE-1:0] im_write_address,
    output logic [DATA_SIZE-1:0]    im_write_data,
    output logic [ADDRESS_SIZE-1:0] im_read_address,
    input  logic [DATA_SIZE-1:0]    im_read_data,
    output logic                    dm_write_enable,
    output logic [ADDRESS_SIZE-1:0] dm_write_address,
    output logic [DATA_SIZE-1:0]    dm_write_data,
    output logic [ADDRESS_SIZE-1:0] dm_read_address,
    input  logic [DATA_SIZE-1:0]    dm_read_data
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    logic [ADDRESS_SIZE-1:0] r_pc;
    logic [ADDRESS_SIZE-1:0] r_if_id_pc;
    logic                    r_if_id_valid;
    logic [DATA_SIZE-1:0]    IF_ID_IR;

    logic [DATA_SIZE-1:0]    ID_EX_A, ID_EX_B, ID_EX_imm;
    logic [4:0]              ID_EX_rd, ID_EX_rt, ID_EX_rs;
    logic [5:0]              ID_EX_op, ID_EX_funct;
    logic                    ID_EX_valid;
    logic [ADDRESS_SIZE-1:0] ID_EX_pc;

    logic [DATA_SIZE-1:0]    EX_MEM_result, EX_MEM_B;
    logic [4:0]              EX_MEM_dest;
    logic [5:0]              EX_MEM_op;
    logic                    EX_MEM_valid;

    logic [DATA_SIZE-1:0]    MEM_WB_result, MEM_WB_data;
    logic [4:0]              MEM_WB_dest;
    logic [5:0]              MEM_WB_op;
    logic                    MEM_WB_valid;

    logic [4:0]              WB_dest;
    logic [DATA_SIZE-1:0]    WB_value;
    logic                    WB_WEenable;

    logic                    ex_stall_c, mem_stall_c;

    logic [DATA_SIZE-1:0]    regs [0:31];

    // Decode fields of the instruction sitting in ID.
    logic [5:0]              w_id_op;
    logic [4:0]              w_id_rs, w_id_rt, w_id_rd;
    logic [DATA_SIZE-1:0]    w_id_imm, w_id_a, w_id_b;
    logic                    w_id_uses_rt;

    assign w_id_op      = IF_ID_IR[31:26];
    assign w_id_rs      = IF_ID_IR[25:21];
    assign w_id_rt      = IF_ID_IR[20:16];
    assign w_id_rd      = IF_ID_IR[15:11];
    assign w_id_imm     = {{(DATA_SIZE-16){IF_ID_IR[15]}}, IF_ID_IR[15:0]};
    assign w_id_uses_rt = (w_id_op == c_OP_RTYPE) || (w_id_op == c_OP_SW) ||
                          (w_id_op == c_OP_BEQ);

    // Write-through: a register committed this cycle is visible to ID already.
    assign w_id_a = (w_id_rs == 5'd0) ? '0 :
                    (WB_WEenable && (WB_dest == w_id_rs)) ? WB_value : regs[w_id_rs];
    assign w_id_b = (w_id_rt == 5'd0) ? '0 :
                    (WB_WEenable && (WB_dest == w_id_rt)) ? WB_value : regs[w_id_rt];

    logic [DATA_SIZE-1:0]    w_ex_result;
    logic [4:0]              w_ex_dest;

    always_comb begin
        w_ex_result = '0;
        w_ex_dest   = 5'd0;
        if (ID_EX_valid) begin
            case (ID_EX_op)
                c_OP_RTYPE: begin
                    case (ID_EX_funct)
                        c_FN_ADD: begin w_ex_result = ID_EX_A + ID_EX_B; w_ex_dest = ID_EX_rd; end
                        c_FN_SUB: begin w_ex_result = ID_EX_A - ID_EX_B; w_ex_dest = ID_EX_rd; end
                        c_FN_AND: begin w_ex_result = ID_EX_A & ID_EX_B; w_ex_dest = ID_EX_rd; end
                        c_FN_OR:  begin w_ex_result = ID_EX_A | ID_EX_B; w_ex_dest = ID_EX_rd; end
                        c_FN_SLT: begin
                            w_ex_result = {{(DATA_SIZE-1){1'b0}},
                                           ($signed(ID_EX_A) < $signed(ID_EX_B))};
                            w_ex_dest   = ID_EX_rd;
                        end
                        default: ;
                    endcase
                end
                c_OP_ADDI, c_OP_LW: begin
                    w_ex_result = ID_EX_A + ID_EX_imm;
                    w_ex_dest   = ID_EX_rt;
                end
                c_OP_SW: w_ex_result = ID_EX_A + ID_EX_imm;
                default: ;
            endcase
        end
    end

    logic                    w_taken;
    logic [ADDRESS_SIZE-1:0] w_branch_target;
    logic                    w_stall;

    assign w_taken         = ID_EX_valid && (ID_EX_op == c_OP_BEQ) && (ID_EX_A == ID_EX_B);
    assign w_branch_target = ID_EX_pc + {{(ADDRESS_SIZE-1){1'b0}}, 1'b1} +
                             ADDRESS_SIZE'(ID_EX_imm);

    assign ex_stall_c  = ID_EX_valid && (w_ex_dest != 5'd0) &&
                         ((w_ex_dest == w_id_rs) || (w_id_uses_rt && (w_ex_dest == w_id_rt)));
    assign mem_stall_c = EX_MEM_valid && (EX_MEM_dest != 5'd0) &&
                         ((EX_MEM_dest == w_id_rs) || (w_id_uses_rt && (EX_MEM_dest == w_id_rt)));
    assign w_stall     = ex_stall_c || mem_stall_c;

    assign WB_dest     = MEM_WB_dest;
    assign WB_value    = (MEM_WB_op == c_OP_LW) ? MEM_WB_data : MEM_WB_result;
    assign WB_WEenable = MEM_WB_valid && (MEM_WB_dest != 5'd0);

    assign im_write_enable  = 1'b0;
    assign im_write_address = '0;
    assign im_write_data    = '0;
    assign im_read_address  = r_pc;

    assign dm_read_address  = ADDRESS_SIZE'(EX_MEM_result);
    assign dm_write_address = ADDRESS_SIZE'(EX_MEM_result);
    assign dm_write_data    = EX_MEM_B;
    assign dm_write_enable  = EX_MEM_valid && (EX_MEM_op == c_OP_SW);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= '0;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
            IF_ID_IR      <= '0;
            ID_EX_A       <= '0;
            ID_EX_B       <= '0;
            ID_EX_imm     <= '0;
            ID_EX_rd      <= '0;
            ID_EX_rt      <= '0;
            ID_EX_rs      <= '0;
            ID_EX_op      <= '0;
            ID_EX_funct   <= '0;
            ID_EX_valid   <= 1'b0;
            ID_EX_pc      <= '0;
            EX_MEM_result <= '0;
            EX_MEM_B      <= '0;
            EX_MEM_dest   <= '0;
            EX_MEM_op     <= '0;
            EX_MEM_valid  <= 1'b0;
            MEM_WB_result <= '0;
            MEM_WB_data   <= '0;
            MEM_WB_dest   <= '0;
            MEM_WB_op     <= '0;
            MEM_WB_valid  <= 1'b0;
        end else begin
            // A taken branch wins over any interlock raised by the wrong-path ID.
            if (w_taken) begin
                r_pc          <= w_branch_target;
                IF_ID_IR      <= '0;
                r_if_id_valid <= 1'b0;
            end else if (!w_stall) begin
                r_pc          <= r_pc + {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
                IF_ID_IR      <= im_read_data;
                r_if_id_pc    <= r_pc;
                r_if_id_valid <= 1'b1;
            end

            if (w_taken || w_stall) begin
                ID_EX_A     <= '0;
                ID_EX_B     <= '0;
                ID_EX_imm   <= '0;
                ID_EX_rd    <= '0;
                ID_EX_rt    <= '0;
                ID_EX_rs    <= '0;
                ID_EX_op    <= '0;
                ID_EX_funct <= '0;
                ID_EX_valid <= 1'b0;
                ID_EX_pc    <= '0;
            end else begin
                ID_EX_A     <= w_id_a;
                ID_EX_B     <= w_id_b;
                ID_EX_imm   <= w_id_imm;
                ID_EX_rd    <= w_id_rd;
                ID_EX_rt    <= w_id_rt;
                ID_EX_rs    <= w_id_rs;
                ID_EX_op    <= w_id_op;
                ID_EX_funct <= IF_ID_IR[5:0];
                ID_EX_valid <= r_if_id_valid;
                ID_EX_pc    <= r_if_id_pc;
            end

            EX_MEM_result <= w_ex_result;
            EX_MEM_B      <= ID_EX_B;
            EX_MEM_dest   <= w_ex_dest;
            EX_MEM_op     <= ID_EX_op;
            EX_MEM_valid  <= ID_EX_valid;

            MEM_WB_result <= EX_MEM_result;
            MEM_WB_data   <= dm_read_data;
            MEM_WB_dest   <= EX_MEM_dest;
            MEM_WB_op     <= EX_MEM_op;
            MEM_WB_valid  <= EX_MEM_valid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (WB_WEenable) begin
            regs[WB_dest] <= WB_value;
        end
    end

    // Fields carried for observability only.
    logic w_unused;
    assign w_unused = ^{ID_EX_rs, IF_ID_IR[10:6]};

endmodule
`default_nettype wire

// File: tb/tb_mips5_pipeline_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips5_pipeline_core
// Brief    : Directed cycle-accurate bench for the 5-stage MIPS-subset core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips5_pipeline_core;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        im_write_enable;
    logic [31:0] im_write_address, im_write_data, im_read_address, im_read_data;
    logic        dm_write_enable;
    logic [31:0] dm_write_address, dm_write_data, dm_read_address, dm_read_data;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    assign im_read_data = imem[im_read_address[5:0]];
    assign dm_read_data = dmem[dm_read_address[5:0]];
    always @(posedge clock) if (dm_write_enable) dmem[dm_write_address[5:0]] <= dm_write_data;

    mips5_pipeline_core #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .im_write_enable  (im_write_enable),
        .im_write_address (im_write_address),
        .im_write_data    (im_write_data),
        .im_read_address  (im_read_address),
        .im_read_data     (im_read_data),
        .dm_write_enable  (dm_write_enable),
        .dm_write_address (dm_write_address),
        .dm_write_data    (dm_write_data),
        .dm_read_address  (dm_read_address),
        .dm_read_data     (dm_read_data)
    );

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_wb(input string tag, input logic [4:0] dest, input logic [31:0] exp);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (dut.WB_WEenable && dut.WB_dest == dest) found = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, found}, 32'd1);
        if (found) check({tag, "_value"}, dut.WB_value, exp);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);      // addi $1,$0,5
        imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);      // addi $2,$0,7
        imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);       // add  $3,$1,$2
        imem[3]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd4);      // sw   $3,4($0)
        imem[4]  = enc_i(6'h23, 5'd0, 5'd4, 16'd4);      // lw   $4,4($0)
        imem[5]  = enc_r(5'd4, 5'd1, 5'd5, 6'h22);       // sub  $5,$4,$1
        imem[6]  = enc_i(6'h04, 5'd0, 5'd0, 16'd2);      // beq  $0,$0,+2
        imem[7]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);      // squashed
        imem[8]  = enc_i(6'h08, 5'd0, 5'd7, 16'd1);      // squashed
        imem[9]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);      // addi $0,$0,9
        imem[10] = enc_i(6'h08, 5'd0, 5'd8, 16'hFFFF);   // addi $8,$0,-1
        imem[11] = enc_r(5'd8, 5'd0, 5'd9, 6'h2A);       // slt  $9,$8,$0
        imem[12] = enc_r(5'd0, 5'd8, 5'd10, 6'h2A);      // slt  $10,$0,$8
        imem[13] = enc_r(5'd3, 5'd5, 5'd11, 6'h24);      // and  $11,$3,$5
        imem[14] = enc_r(5'd3, 5'd5, 5'd12, 6'h25);      // or   $12,$3,$5

        reset_n = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("rst_pc",       im_read_address, 32'd0);
        check("rst_ifid",     dut.IF_ID_IR, 32'd0);
        check("rst_idex_v",   {31'd0, dut.ID_EX_valid}, 32'd0);
        check("rst_exmem_v",  {31'd0, dut.EX_MEM_valid}, 32'd0);
        check("rst_memwb_v",  {31'd0, dut.MEM_WB_valid}, 32'd0);
        check("rst_wbwe",     {31'd0, dut.WB_WEenable}, 32'd0);
        check("rst_dmwe",     {31'd0, dm_write_enable}, 32'd0);
        check("rst_stalls",   {30'd0, dut.ex_stall_c, dut.mem_stall_c}, 32'd0);
        check("imem_we_tied", {31'd0, im_write_enable}, 32'd0);

        @(negedge clock);
        reset_n = 1'b1;

        step(); // edge 1
        check("e1_ifid", dut.IF_ID_IR, imem[0]);
        check("e1_pc",   im_read_address, 32'd1);
        step(); step(); // edge 3: add in ID behind both addi
        check("e3_ifid",  dut.IF_ID_IR, imem[2]);
        check("e3_exstl", {31'd0, dut.ex_stall_c}, 32'd1);
        check("e3_mmstl", {31'd0, dut.mem_stall_c}, 32'd1);
        step(); // edge 4
        check("e4_wbwe",  {31'd0, dut.WB_WEenable}, 32'd1);
        check("e4_wbdst", {27'd0, dut.WB_dest}, 32'd1);
        check("e4_wbval", dut.WB_value, 32'd5);
        check("e4_exstl", {31'd0, dut.ex_stall_c}, 32'd0);
        check("e4_mmstl", {31'd0, dut.mem_stall_c}, 32'd1);
        check("e4_pc_hold", im_read_address, 32'd3);
        step(); // edge 5
        check("e5_wbdst", {27'd0, dut.WB_dest}, 32'd2);
        check("e5_wbval", dut.WB_value, 32'd7);
        check("e5_nostl", {30'd0, dut.ex_stall_c, dut.mem_stall_c}, 32'd0);
        step(); // edge 6
        check("e6_idex_a", dut.ID_EX_A, 32'd5);
        check("e6_idex_b", dut.ID_EX_B, 32'd7);
        check("e6_sw_stl", {31'd0, dut.ex_stall_c}, 32'd1);
        step(); step(); // edge 8
        check("e8_wbdst", {27'd0, dut.WB_dest}, 32'd3);
        check("e8_wbval", dut.WB_value, 32'd12);
        step(); step(); // edge 10: sw in MEM, sub stalled behind lw
        check("e10_dmwe",   {31'd0, dm_write_enable}, 32'd1);
        check("e10_dmaddr", dm_write_address, 32'd4);
        check("e10_dmdata", dm_write_data, 32'd12);
        check("e10_exstl",  {31'd0, dut.ex_stall_c}, 32'd1);
        step(); // edge 11
        check("e11_dmem4", dmem[4], 32'd12);
        check("e11_mmstl", {31'd0, dut.mem_stall_c}, 32'd1);
        step(); // edge 12
        check("e12_wbdst", {27'd0, dut.WB_dest}, 32'd4);
        check("e12_wbval", dut.WB_value, 32'd12);
        step(); step(); step(); // edge 15: beq taken
        check("e15_pc",     im_read_address, 32'd9);
        check("e15_ifid",   dut.IF_ID_IR, 32'd0);
        check("e15_idex_v", {31'd0, dut.ID_EX_valid}, 32'd0);
        check("e15_wbdst",  {27'd0, dut.WB_dest}, 32'd5);
        check("e15_wbval",  dut.WB_value, 32'd7);
        step(); // edge 16
        check("e16_idex_v", {31'd0, dut.ID_EX_valid}, 32'd0);
        check("e16_ifid",   dut.IF_ID_IR, imem[9]);
        step(); step(); step(); // edge 19: addi $0 in WB
        check("e19_memwb_v", {31'd0, dut.MEM_WB_valid}, 32'd1);
        check("e19_wbdst",   {27'd0, dut.WB_dest}, 32'd0);
        check("e19_wbwe",    {31'd0, dut.WB_WEenable}, 32'd0);

        wait_wb("slt9",  5'd9,  32'd1);
        wait_wb("slt10", 5'd10, 32'd0);
        wait_wb("and11", 5'd11, 32'd4);
        wait_wb("or12",  5'd12, 32'd15);
        repeat (3) step();

        check("reg0",  dut.regs[0],  32'd0);
        check("reg3",  dut.regs[3],  32'd12);
        check("reg4",  dut.regs[4],  32'd12);
        check("reg5",  dut.regs[5],  32'd7);
        check("reg6",  dut.regs[6],  32'd0);
        check("reg7",  dut.regs[7],  32'd0);
        check("reg8",  dut.regs[8],  32'hFFFFFFFF);
        check("reg9",  dut.regs[9],  32'd1);
        check("reg12", dut.regs[12], 32'd15);

        // Asynchronous reset in the middle of a cycle with work in flight.
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_pc",      im_read_address, 32'd0);
        check("mrst_ifid",    dut.IF_ID_IR, 32'd0);
        check("mrst_idex_v",  {31'd0, dut.ID_EX_valid}, 32'd0);
        check("mrst_exmem_v", {31'd0, dut.EX_MEM_valid}, 32'd0);
        check("mrst_reg3",    dut.regs[3], 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check("rr_ifid", dut.IF_ID_IR, imem[0]);
        step(); step();
        check("rr_stall", {31'd0, dut.ex_stall_c}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
